// File: rtl/mxv_result_tx.sv
// Frames a captured MxV result vector as HDR, n, results (MSB byte first), TRL and feeds the UART TX.
// Latency: first TX_START 2 cycles after LOAD; each later TX_START 2 cycles after the previous TX_DONE.
// Backpressure: one byte in flight; the next byte waits for TX_DONE, and LOAD is ignored while busy.
module mxv_result_tx #(
    parameter int         MAX_N    = 8,
    parameter int         RES_W    = 16,
    parameter logic [7:0] HDR_BYTE = 8'hFE,
    parameter logic [7:0] TRL_BYTE = 8'hEF
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   LOAD,
    input  logic [3:0]             N_SIZE,
    input  logic [MAX_N*RES_W-1:0] RESULTS,
    input  logic                   TX_DONE,
    output logic [7:0]             TX_DATA,
    output logic                   TX_START,
    output logic                   BUSY,
    output logic                   FRAME_DONE
);

    localparam int BPE   = RES_W / 8;
    localparam int BUF_W = MAX_N * RES_W;

    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_DONE} state_t;

    state_t             state, state_nxt;
    logic [7:0]         k, k_nxt;
    logic [3:0]         n, n_nxt;
    logic [BUF_W-1:0]   res_buf, res_buf_nxt;
    logic [7:0]         last_k;
    logic [7:0]         cur_byte;
    logic [7:0]         tx_data_nxt;
    logic               tx_start_nxt, busy_nxt, frame_done_nxt;
    int                 off, elem, pos;

    assign last_k = 8'(int'(n) * BPE + 2);

    // Payload byte k maps to element (k-2)/BPE, counting bytes from the element's MSB.
    always_comb begin
        off      = int'(k) - 2;
        elem     = off / BPE;
        pos      = elem * RES_W + (BPE - 1 - (off % BPE)) * 8;
        cur_byte = 8'h00;
        if (k == 8'd0)
            cur_byte = HDR_BYTE;
        else if (k == 8'd1)
            cur_byte = {4'b0000, n};
        else if (k == last_k)
            cur_byte = TRL_BYTE;
        else if (elem < MAX_N)
            cur_byte = res_buf[pos +: 8];
    end

    always_comb begin
        state_nxt      = state;
        k_nxt          = k;
        n_nxt          = n;
        res_buf_nxt    = res_buf;
        tx_data_nxt    = TX_DATA;
        tx_start_nxt   = 1'b0;
        busy_nxt       = BUSY;
        frame_done_nxt = 1'b0;
        case (state)
            S_IDLE: begin
                if (LOAD) begin
                    res_buf_nxt = RESULTS;
                    n_nxt       = (int'(N_SIZE) > MAX_N) ? 4'(MAX_N) : N_SIZE;
                    k_nxt       = 8'd0;
                    busy_nxt    = 1'b1;
                    state_nxt   = S_ISSUE;
                end
            end
            S_ISSUE: begin
                tx_data_nxt  = cur_byte;
                tx_start_nxt = 1'b1;
                state_nxt    = S_WAIT;
            end
            S_WAIT: begin
                if (TX_DONE) begin
                    if (k == last_k) begin
                        frame_done_nxt = 1'b1;
                        state_nxt      = S_DONE;
                    end else begin
                        k_nxt     = k + 8'd1;
                        state_nxt = S_ISSUE;
                    end
                end
            end
            S_DONE: begin
                busy_nxt  = 1'b0;
                state_nxt = S_IDLE;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= S_IDLE;
            k          <= 8'd0;
            n          <= 4'd0;
            res_buf    <= '0;
            TX_DATA    <= 8'h00;
            TX_START   <= 1'b0;
            BUSY       <= 1'b0;
            FRAME_DONE <= 1'b0;
        end else begin
            state      <= state_nxt;
            k          <= k_nxt;
            n          <= n_nxt;
            res_buf    <= res_buf_nxt;
            TX_DATA    <= tx_data_nxt;
            TX_START   <= tx_start_nxt;
            BUSY       <= busy_nxt;
            FRAME_DONE <= frame_done_nxt;
        end
    end

endmodule

// File: tb/tb_mxv_result_tx.sv
// Directed bench for mxv_result_tx: a UART stand-in answers each TX_START with TX_DONE after a delay.
// Latency checked: first TX_START 2 cycles after LOAD, next TX_START 2 cycles after TX_DONE.
// Backpressure exercised through TX_DONE delay, LOAD while busy, spurious TX_DONE and mid-frame reset.
module tb_mxv_result_tx;

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic         load = 1'b0;
    logic [3:0]   n_size = 4'd0;
    logic [127:0] results = '0;
    logic         tx_done = 1'b0;
    logic [7:0]   tx_data;
    logic         tx_start;
    logic         busy;
    logic         frame_done;

    int vectors = 0;
    int miscompares = 0;

    logic [7:0] got[$];
    logic [7:0] exp_q[$];
    int starts, first_lat, spacing_bad, busy_drop, fd_lat, timeout;

    mxv_result_tx dut (
        .clk(clk), .rst(rst), .LOAD(load), .N_SIZE(n_size), .RESULTS(results),
        .TX_DONE(tx_done), .TX_DATA(tx_data), .TX_START(tx_start), .BUSY(busy),
        .FRAME_DONE(frame_done)
    );

    always #5 clk = ~clk;

    task automatic do_load(input logic spur);
        @(negedge clk);
        load = 1'b1;
        @(negedge clk);
        load    = 1'b0;
        tx_done = spur;
    endtask

    // Behaves as the UART: answers each TX_START after 'gap' cycles. Optionally pulses LOAD with the
    // TX_DONE of byte inject_at, or returns right after byte abort_at has been started.
    task automatic capture_frame(input int gap, input int inject_at, input int abort_at);
        int cyc, cnt, done_cyc, fd;
        got.delete();
        starts = 0; first_lat = -1; spacing_bad = 0; busy_drop = 0; fd_lat = -1;
        cyc = 0; cnt = 0; done_cyc = -1; fd = 0;
        while (fd == 0 && cyc < 3000) begin
            @(negedge clk);
            cyc++;
            tx_done = 1'b0;
            load    = 1'b0;
            if (tx_start) begin
                if (first_lat < 0) first_lat = cyc;
                if (done_cyc >= 0 && cyc - done_cyc != 2) spacing_bad++;
                if (!busy) busy_drop++;
                got.push_back(tx_data);
                starts++;
                cnt = gap;
                if (abort_at >= 0 && starts == abort_at + 1) return;
            end else if (cnt > 0) begin
                cnt--;
                if (cnt == 0) begin
                    tx_done  = 1'b1;
                    done_cyc = cyc;
                    if (inject_at >= 0 && starts == inject_at + 1) load = 1'b1;
                end
            end
            if (frame_done) begin
                fd     = 1;
                fd_lat = cyc - done_cyc;
            end
        end
        timeout = (fd == 0);
    endtask

    task automatic test_reset;
        repeat (3) @(negedge clk);
        vectors++;
        if ({tx_data, tx_start, busy, frame_done} !== 11'h000) begin
            miscompares++;
            $display("FAIL reset outputs got %h/%b/%b/%b want 00/0/0/0", tx_data, tx_start, busy, frame_done);
        end
        rst = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_basic;
        results = {96'h0, 16'hABCD, 16'h1234};
        n_size  = 4'd2;
        exp_q   = '{8'hFE, 8'h02, 8'h12, 8'h34, 8'hAB, 8'hCD, 8'hEF};
        do_load(1'b0);
        capture_frame(5, -1, -1);
        vectors++; if (timeout != 0) begin miscompares++; $display("FAIL basic timeout got %0d want 0", timeout); end
        vectors++; if (starts != 7) begin miscompares++; $display("FAIL basic starts got %0d want 7", starts); end
        for (int i = 0; i < exp_q.size(); i++) begin
            vectors++;
            if (i >= got.size() || got[i] !== exp_q[i]) begin
                miscompares++;
                $display("FAIL basic byte%0d got %h want %h", i, (i < got.size()) ? got[i] : 8'hxx, exp_q[i]);
            end
        end
        vectors++; if (first_lat != 1) begin miscompares++; $display("FAIL basic first_latency got %0d want 1", first_lat); end
        vectors++; if (spacing_bad != 0) begin miscompares++; $display("FAIL basic start_spacing got %0d bad want 0", spacing_bad); end
        vectors++; if (busy_drop != 0) begin miscompares++; $display("FAIL basic busy_during got %0d low want 0", busy_drop); end
        vectors++; if (fd_lat != 1) begin miscompares++; $display("FAIL basic frame_done_latency got %0d want 1", fd_lat); end
        @(negedge clk);
        vectors++;
        if ({busy, frame_done, tx_start} !== 3'b000) begin
            miscompares++;
            $display("FAIL basic after busy/fd/start got %b%b%b want 000", busy, frame_done, tx_start);
        end
    endtask

    task automatic test_empty;
        n_size = 4'd0;
        exp_q  = '{8'hFE, 8'h00, 8'hEF};
        do_load(1'b0);
        capture_frame(3, -1, -1);
        vectors++; if (timeout != 0) begin miscompares++; $display("FAIL empty timeout got %0d want 0", timeout); end
        vectors++; if (starts != 3) begin miscompares++; $display("FAIL empty starts got %0d want 3", starts); end
        for (int i = 0; i < exp_q.size(); i++) begin
            vectors++;
            if (i >= got.size() || got[i] !== exp_q[i]) begin
                miscompares++;
                $display("FAIL empty byte%0d got %h want %h", i, (i < got.size()) ? got[i] : 8'hxx, exp_q[i]);
            end
        end
        @(negedge clk);
        vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL empty busy_after got %b want 0", busy); end
    endtask

    task automatic test_clamp;
        results = {8{16'h00FF}};
        n_size  = 4'd12;
        exp_q   = '{8'hFE, 8'h08};
        for (int i = 0; i < 8; i++) begin
            exp_q.push_back(8'h00);
            exp_q.push_back(8'hFF);
        end
        exp_q.push_back(8'hEF);
        do_load(1'b0);
        capture_frame(1, -1, -1);
        vectors++; if (timeout != 0) begin miscompares++; $display("FAIL clamp timeout got %0d want 0", timeout); end
        vectors++; if (starts != 19) begin miscompares++; $display("FAIL clamp starts got %0d want 19", starts); end
        for (int i = 0; i < exp_q.size(); i++) begin
            vectors++;
            if (i >= got.size() || got[i] !== exp_q[i]) begin
                miscompares++;
                $display("FAIL clamp byte%0d got %h want %h", i, (i < got.size()) ? got[i] : 8'hxx, exp_q[i]);
            end
        end
        @(negedge clk);
    endtask

    task automatic test_load_while_busy;
        results = {96'h0, 16'h5A5A, 16'hC3C3};
        n_size  = 4'd2;
        exp_q   = '{8'hFE, 8'h02, 8'hC3, 8'hC3, 8'h5A, 8'h5A, 8'hEF};
        do_load(1'b0);
        results = {80'h0, 16'h0102, 16'h0304, 16'h0506};
        n_size  = 4'd3;
        capture_frame(4, 3, -1);
        vectors++; if (starts != 7) begin miscompares++; $display("FAIL busyload starts got %0d want 7", starts); end
        for (int i = 0; i < exp_q.size(); i++) begin
            vectors++;
            if (i >= got.size() || got[i] !== exp_q[i]) begin
                miscompares++;
                $display("FAIL busyload byte%0d got %h want %h", i, (i < got.size()) ? got[i] : 8'hxx, exp_q[i]);
            end
        end
        repeat (3) @(negedge clk);
        vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL busyload idle_busy got %b want 0", busy); end
        exp_q = '{8'hFE, 8'h03, 8'h05, 8'h06, 8'h03, 8'h04, 8'h01, 8'h02, 8'hEF};
        do_load(1'b0);
        capture_frame(2, -1, -1);
        vectors++; if (timeout != 0) begin miscompares++; $display("FAIL reload timeout got %0d want 0", timeout); end
        for (int i = 0; i < exp_q.size(); i++) begin
            vectors++;
            if (i >= got.size() || got[i] !== exp_q[i]) begin
                miscompares++;
                $display("FAIL reload byte%0d got %h want %h", i, (i < got.size()) ? got[i] : 8'hxx, exp_q[i]);
            end
        end
        @(negedge clk);
    endtask

    task automatic test_spurious_done;
        int seen;
        seen = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            tx_done = (i % 2 == 0);
            if (tx_start || busy) seen++;
        end
        @(negedge clk);
        tx_done = 1'b0;
        if (tx_start || busy) seen++;
        vectors++; if (seen != 0) begin miscompares++; $display("FAIL spurious idle_activity got %0d want 0", seen); end
        results = {112'h0, 16'hBEEF};
        n_size  = 4'd1;
        exp_q   = '{8'hFE, 8'h01, 8'hBE, 8'hEF, 8'hEF};
        do_load(1'b1);
        capture_frame(3, -1, -1);
        vectors++; if (starts != 5) begin miscompares++; $display("FAIL spurious starts got %0d want 5", starts); end
        for (int i = 0; i < exp_q.size(); i++) begin
            vectors++;
            if (i >= got.size() || got[i] !== exp_q[i]) begin
                miscompares++;
                $display("FAIL spurious byte%0d got %h want %h", i, (i < got.size()) ? got[i] : 8'hxx, exp_q[i]);
            end
        end
        @(negedge clk);
    endtask

    task automatic test_reset_mid_frame;
        int seen;
        results = {80'h0, 16'h0102, 16'h0304, 16'h0506};
        n_size  = 4'd3;
        exp_q   = '{8'hFE, 8'h03, 8'h05, 8'h06, 8'h03, 8'h04, 8'h01, 8'h02, 8'hEF};
        do_load(1'b0);
        capture_frame(4, -1, 4);
        vectors++; if (starts != 5) begin miscompares++; $display("FAIL rstmid reached got %0d starts want 5", starts); end
        rst = 1'b0;
        #1;
        vectors++;
        if ({tx_data, tx_start, busy, frame_done} !== 11'h000) begin
            miscompares++;
            $display("FAIL rstmid outputs got %h/%b/%b/%b want 00/0/0/0", tx_data, tx_start, busy, frame_done);
        end
        @(negedge clk);
        rst  = 1'b1;
        seen = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            tx_done = (i % 4 == 1);
            if (tx_start || busy) seen++;
        end
        tx_done = 1'b0;
        vectors++; if (seen != 0) begin miscompares++; $display("FAIL rstmid post_release_activity got %0d want 0", seen); end
        do_load(1'b0);
        capture_frame(2, -1, -1);
        vectors++; if (starts != 9) begin miscompares++; $display("FAIL rstmid new_starts got %0d want 9", starts); end
        for (int i = 0; i < exp_q.size(); i++) begin
            vectors++;
            if (i >= got.size() || got[i] !== exp_q[i]) begin
                miscompares++;
                $display("FAIL rstmid byte%0d got %h want %h", i, (i < got.size()) ? got[i] : 8'hxx, exp_q[i]);
            end
        end
        @(negedge clk);
    endtask

    initial begin
        test_reset();
        test_basic();
        test_empty();
        test_clamp();
        test_load_while_busy();
        test_spurious_done();
        test_reset_mid_frame();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/mxv_result_tx.md
Name: mxv_result_tx

Overview:
- Transmit side of the MxV serial link.
- Captures the result vector produced by the processor once an operation completes.
- Frames the vector as a byte stream: header, length, results (MSB byte first), trailer.
- Drives the UART transmitter one byte at a time, using a start/done handshake.

Parameters:
MAX_N, 8, maximum number of result elements per frame
RES_W, 16, width of one result element in bits (multiple of 8)
HDR_BYTE, 8'hFE, frame header byte
TRL_BYTE, 8'hEF, frame trailer byte

Ports:
clk  input  1  system clock
rst  input  1  asynchronous reset, active low
LOAD  input  1  one-cycle pulse: capture RESULTS and N_SIZE, start frame
N_SIZE  input  4  number of valid results in RESULTS
RESULTS  input  MAX_N*RES_W  packed results; element i = RESULTS[i*RES_W +: RES_W]
TX_DONE  input  1  one-cycle pulse from UART TX: current byte fully shifted out
TX_DATA  output  8  byte presented to UART TX
TX_START  output  1  one-cycle pulse: UART TX loads TX_DATA
BUSY  output  1  high from the cycle after an accepted LOAD until FRAME_DONE
FRAME_DONE  output  1  one-cycle pulse after the trailer byte's TX_DONE

Behaviour:
- Reset values (rst=0, async): TX_DATA=0, TX_START=0, BUSY=0, FRAME_DONE=0, FSM=IDLE, byte index=0, buffer cleared.
- Reset mid-frame aborts immediately. No further TX_START issues after reset release until a new LOAD.
- LOAD capture:
  - LOAD is accepted only in IDLE. Accepting it latches RESULTS into an internal buffer and latches n = min(N_SIZE, MAX_N).
  - LOAD while BUSY is ignored. The buffer and n stay unchanged.
- Frame byte sequence, index k = 0..L-1, L = 3 + n*(RES_W/8):
  - k=0: HDR_BYTE.
  - k=1: n, zero-extended to 8 bits.
  - Then element 0..n-1, each MSB byte first.
  - Last byte: TRL_BYTE.
- n=0 gives the 3-byte frame FE 00 EF.
- FSM states: IDLE, ISSUE, WAIT, DONE.
  - IDLE: on LOAD -> ISSUE, k=0, BUSY=1.
  - ISSUE (1 cycle): TX_DATA <= byte(k), TX_START=1 -> WAIT.
  - WAIT: TX_START=0, TX_DATA held. On TX_DONE: if k==L-1 -> DONE; else k++ and -> ISSUE.
  - DONE (1 cycle): FRAME_DONE=1, BUSY=0 on exit -> IDLE.
- Latency:
  - First TX_START occurs 2 cycles after the LOAD cycle (IDLE->ISSUE register, then ISSUE output registered).
  - Each following TX_START occurs exactly 2 cycles after the preceding TX_DONE.
- TX_START is never asserted twice for one byte. At most one TX_START per TX_DONE received.
- TX_DONE outside WAIT (IDLE, ISSUE, DONE) is ignored and does not advance k.
- TX_DONE and LOAD in the same cycle while BUSY: TX_DONE is processed and LOAD is dropped.
- Byte selection from the buffer uses k-2 as the byte offset. element = (k-2)/(RES_W/8); byte within element counts from the MSB.
- The buffer is read only; it is not modified during a frame.
- Outputs are registered. There is no combinational path from inputs to outputs.

Test Plan:
1. n=2, RESULTS elem0=16'h1234, elem1=16'hABCD, TX_DONE returned 5 cycles after each TX_START -> TX_DATA sequence FE 02 12 34 AB CD EF. Exactly 7 TX_START pulses, then one FRAME_DONE pulse, BUSY low afterwards.
2. N_SIZE=0 -> bytes FE 00 EF, 3 TX_START pulses, FRAME_DONE.
3. N_SIZE=12 with MAX_N=8, all elements 16'h00FF -> length byte 08, 16 payload bytes alternating 00 FF, 19 bytes total.
4. Second LOAD with different RESULTS asserted during byte 3 of a frame -> ignored. Transmitted bytes match the first capture; a LOAD after FRAME_DONE starts a new frame.
5. Spurious TX_DONE pulses in IDLE and in the ISSUE cycle -> no TX_START, k unchanged, frame content unaffected.
6. rst asserted low while in WAIT at k=4 -> all outputs 0 within the same cycle, no TX_START after release. A new LOAD then produces a complete frame from FE.
